psr_stack: RTL and testbench

//  Parametrised processor status register with per-flag write enables, whole-word

---
 rtl/psr_pkg.sv | 14 +
 rtl/psr_lifo.sv | 62 ++++++
 rtl/psr_stack.sv | 87 ++++++++
 tb/tb_psr_stack.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psr_pkg.sv
// Shared definitions for the processor status register block: flag bit
// positions within the PSR word and the default build sizes.
package psr_pkg;

    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam int DEFAULT_NFLAGS = 5;
    localparam int DEFAULT_DEPTH  = 4;

endpackage

// File: rtl/psr_lifo.sv
// Storage for saved PSR words. The caller guarantees that at most one of
// push/pop/swap is asserted per cycle and only when it is legal (push when not
// full, pop/swap when not empty); this block just performs the operation.
module psr_lifo
    import psr_pkg::*;
#(
    parameter  int W     = DEFAULT_NFLAGS,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          swap,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [W-1:0] mem [DEPTH];

    // Occupancy count and entry writes; push fills the slot at the current
    // level, swap overwrites the current top entry in place.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                level <= level + 1'b1;
            end else if (pop) begin
                level <= level - 1'b1;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (level == LW'(i))) begin
                    mem[i] <= din;
                end else if (swap && (level == LW'(i + 1))) begin
                    mem[i] <= din;
                end
            end
        end
    end

    // Top-of-stack word; reads as zero when nothing has been saved.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level == LW'(i + 1)) begin
                top = mem[i];
            end
        end
    end

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/psr_stack.sv
// Live processor status register with per-flag updates, whole-word load and
// a LIFO of saved words for interrupt entry/return. Refused pushes and pops
// raise sticky ovf/unf flags that stay set until clr_err.
module psr_stack
    import psr_pkg::*;
#(
    parameter  int NFLAGS = DEFAULT_NFLAGS,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int LW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NFLAGS-1:0] set_en,
    input  logic [NFLAGS-1:0] flags_d,
    input  logic              wr_all,
    input  logic [NFLAGS-1:0] wr_data,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic [NFLAGS-1:0] psr_q,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);

    logic              doPush;
    logic              doPop;
    logic              doSwap;
    logic              ovfSet;
    logic              unfSet;
    logic [NFLAGS-1:0] topWord;
    logic [NFLAGS-1:0] psrNext;

    psr_lifo #(
        .W     (NFLAGS),
        .DEPTH (DEPTH)
    ) uLifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (doPush),
        .pop     (doPop),
        .swap    (doSwap),
        .din     (psr_q),
        .top     (topWord),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    // Decode push/pop requests into legal stack operations. Push+pop on an
    // empty stack degrades to a plain push; push+pop otherwise is a swap.
    always_comb begin
        doSwap = push && pop && !empty;
        doPush = push && !full && !(pop && !empty);
        doPop  = pop && !push && !empty;
        ovfSet = push && !pop && full;
        unfSet = pop && !push && empty;
    end

    // Live PSR next value: a restore from the stack beats a whole-word load,
    // which beats individual flag updates.
    always_comb begin
        psrNext = (psr_q & ~set_en) | (flags_d & set_en);
        if (doPop || doSwap) begin
            psrNext = topWord;
        end else if (wr_all) begin
            psrNext = wr_data;
        end
    end

    // Live register and sticky error bits; a new error in the same cycle as
    // clr_err keeps the bit set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psr_q <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            psr_q <= psrNext;
            ovf   <= ovfSet || (ovf && !clr_err);
            unf   <= unfSet || (unf && !clr_err);
        end
    end

endmodule

// File: tb/tb_psr_stack.sv
// Self-checking bench for psr_stack: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_psr_stack;

    localparam int NF = 5;
    localparam int DP = 4;
    localparam int LW = $clog2(DP + 1);

    logic          clk;
    logic          reset_n;
    logic [NF-1:0] set_en;
    logic [NF-1:0] flags_d;
    logic          wr_all;
    logic [NF-1:0] wr_data;
    logic          push;
    logic          pop;
    logic          clr_err;
    logic [NF-1:0] psr_q;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;

    int checkCount = 0;
    int passCount  = 0;

    logic [NF-1:0] psrM;
    logic [NF-1:0] stackM [$];
    logic          ovfM;
    logic          unfM;

    psr_stack #(
        .NFLAGS (NF),
        .DEPTH  (DP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .set_en  (set_en),
        .flags_d (flags_d),
        .wr_all  (wr_all),
        .wr_data (wr_data),
        .push    (push),
        .pop     (pop),
        .clr_err (clr_err),
        .psr_q   (psr_q),
        .level   (level),
        .full    (full),
        .empty   (empty),
        .ovf     (ovf),
        .unf     (unf)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) begin
            passCount++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, "_psr"},   32'(psr_q), 32'(psrM));
        checkVal({tag, "_level"}, 32'(level), 32'(stackM.size()));
        checkVal({tag, "_full"},  32'(full),  32'(stackM.size() == DP));
        checkVal({tag, "_empty"}, 32'(empty), 32'(stackM.size() == 0));
        checkVal({tag, "_ovf"},   32'(ovf),   32'(ovfM));
        checkVal({tag, "_unf"},   32'(unf),   32'(unfM));
    endtask

    task automatic resetModel();
        psrM = '0;
        stackM.delete();
        ovfM = 1'b0;
        unfM = 1'b0;
    endtask

    // Drive one cycle of requests, let the edge happen, then advance the model.
    task automatic applyStimulus(input logic pu, input logic po, input logic wa,
                                 input logic [NF-1:0] wd, input logic [NF-1:0] se,
                                 input logic [NF-1:0] fd, input logic ce);
        logic [NF-1:0] live;
        logic [NF-1:0] saved;
        logic          oSet;
        logic          uSet;
        int            n;
        push    = pu;
        pop     = po;
        wr_all  = wa;
        wr_data = wd;
        set_en  = se;
        flags_d = fd;
        clr_err = ce;
        @(posedge clk);
        #1;
        n    = stackM.size();
        live = wa ? wd : ((psrM & ~se) | (fd & se));
        oSet = 1'b0;
        uSet = 1'b0;
        if (pu && po && n > 0) begin
            saved         = stackM[n-1];
            stackM[n-1]   = psrM;
            psrM          = saved;
        end else if (pu && n < DP) begin
            stackM.push_back(psrM);
            psrM = live;
        end else if (pu) begin
            oSet = 1'b1;
            psrM = live;
        end else if (po && n > 0) begin
            psrM = stackM.pop_back();
        end else if (po) begin
            uSet = 1'b1;
            psrM = live;
        end else begin
            psrM = live;
        end
        ovfM = oSet | (ovfM & ~ce);
        unfM = uSet | (unfM & ~ce);
        push = 1'b0; pop = 1'b0; wr_all = 1'b0; set_en = '0; clr_err = 1'b0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        #12;
        resetModel();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        push = 1'b0; pop = 1'b0; wr_all = 1'b0; wr_data = '0;
        set_en = '0; flags_d = '0; clr_err = 1'b0;
        resetModel();
        #2;
        doReset();
        checkOutput("reset");

        // Per-flag update, then a single flag written low.
        applyStimulus(0, 0, 0, 5'h00, 5'b00011, 5'b11111, 0);
        checkOutput("t1a");
        checkVal("t1a_const", 32'(psr_q), 32'h03);
        applyStimulus(0, 0, 0, 5'h00, 5'b10000, 5'b00000, 0);
        checkOutput("t1b");
        checkVal("t1b_const", 32'(psr_q), 32'h03);

        // Push saves the pre-update word while flags still update.
        applyStimulus(0, 0, 1, 5'h0A, 5'h00, 5'h00, 0);
        applyStimulus(1, 0, 0, 5'h00, 5'h1F, 5'h15, 0);
        checkOutput("t2push");
        checkVal("t2push_const", 32'(psr_q), 32'h15);
        applyStimulus(0, 1, 1, 5'h1F, 5'h1F, 5'h1F, 0);
        checkOutput("t2pop");
        checkVal("t2pop_const", 32'(psr_q), 32'h0A);

        // Fill to depth, overflow, then unwind in LIFO order.
        applyStimulus(0, 0, 1, 5'h01, 5'h00, 5'h00, 0);
        for (int k = 2; k <= 5; k++) begin
            applyStimulus(1, 0, 1, NF'(k), 5'h00, 5'h00, 0);
        end
        applyStimulus(1, 0, 0, 5'h00, 5'h00, 5'h00, 0);
        checkOutput("t3full");
        checkVal("t3_ovf", 32'(ovf), 32'h1);
        checkVal("t3_level", 32'(level), 32'd4);
        for (int k = 4; k >= 1; k--) begin
            applyStimulus(0, 1, 0, 5'h00, 5'h00, 5'h00, 0);
            checkOutput("t3pop");
            checkVal("t3pop_const", 32'(psr_q), 32'(k));
        end

        // Underflow still takes the whole-word load; clr_err clears stickies.
        applyStimulus(0, 1, 1, 5'h07, 5'h00, 5'h00, 0);
        checkOutput("t4unf");
        checkVal("t4_unf", 32'(unf), 32'h1);
        checkVal("t4_psr", 32'(psr_q), 32'h07);
        applyStimulus(0, 0, 0, 5'h00, 5'h00, 5'h00, 1);
        checkOutput("t4clr");
        // Same-cycle set beats clear.
        applyStimulus(0, 1, 0, 5'h00, 5'h00, 5'h00, 1);
        checkOutput("t4setwin");
        applyStimulus(0, 0, 0, 5'h00, 5'h00, 5'h00, 1);

        // Swap with two words saved.
        applyStimulus(0, 0, 1, 5'h11, 5'h00, 5'h00, 0);
        applyStimulus(1, 0, 1, 5'h03, 5'h00, 5'h00, 0);
        applyStimulus(1, 0, 1, 5'h1C, 5'h00, 5'h00, 0);
        checkOutput("t5pre");
        applyStimulus(1, 1, 1, 5'h00, 5'h1F, 5'h00, 0);
        checkOutput("t5swap");
        checkVal("t5_psr", 32'(psr_q), 32'h03);
        checkVal("t5_level", 32'(level), 32'd2);
        applyStimulus(0, 1, 0, 5'h00, 5'h00, 5'h00, 0);
        checkOutput("t5pop");
        checkVal("t5_top", 32'(psr_q), 32'h1C);

        // Push+pop on an empty stack acts as a plain push.
        applyStimulus(0, 1, 0, 5'h00, 5'h00, 5'h00, 0);
        applyStimulus(1, 1, 1, 5'h09, 5'h00, 5'h00, 0);
        checkOutput("t5emptyswap");

        // Mid-cycle asynchronous reset with three words saved.
        applyStimulus(1, 0, 1, 5'h0F, 5'h00, 5'h00, 0);
        applyStimulus(1, 0, 0, 5'h00, 5'h00, 5'h00, 0);
        checkVal("t6_prelevel", 32'(level), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        resetModel();
        checkOutput("t6async");
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic: push-heavy and pop-heavy phases to hit both ends.
        for (int i = 0; i < 400; i++) begin
            logic pu;
            logic po;
            if ((i / 50) % 2 == 0) begin
                pu = ($urandom_range(0, 9) < 6);
                po = ($urandom_range(0, 9) < 2);
            end else begin
                pu = ($urandom_range(0, 9) < 2);
                po = ($urandom_range(0, 9) < 6);
            end
            applyStimulus(pu, po, ($urandom_range(0, 3) == 0), NF'($urandom),
                          NF'($urandom), NF'($urandom), ($urandom_range(0, 7) == 0));
            checkOutput("rand");
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
